// File: rtl/pipe_adder_if.sv
// Operand/result bus for pipe_adder: input-side valid/ready with operands,
// output-side valid/ready with result, overflow flag and accumulator view.
// master = operand producer / result consumer, slave = the adder itself.
interface pipe_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] res_o;
  logic             ovf_o;
  logic [WIDTH-1:0] acc_o;

  modport master (
    output in_valid_i, op_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, ovf_o, acc_o
  );

  modport slave (
    input  in_valid_i, op_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, ovf_o, acc_o
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/sub/accumulate unit with valid/ready on both sides.
// The arithmetic happens when a beat enters stage 1; later stages only delay
// the {valid,res,ovf} tuple. Each stage advances when it is empty or when the
// stage after it advances, so bubbles collapse and a full pipe still streams
// at one beat per cycle.
// Optional feature: define PIPE_ADDER_SAT_EN to saturate results (and the
// accumulator) instead of wrapping; ovf_o is raised in both builds.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  pipe_adder_if.slave   bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_res   [STAGES];
  logic             r_ovf   [STAGES];
  logic [WIDTH-1:0] r_acc;

  // w_adv[k] : stage k may load this cycle; w_adv[STAGES] is the consumer.
  logic             w_adv   [STAGES+1];
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_acc_we;
  logic [WIDTH-1:0] w_acc_next;

  assign w_adv[STAGES] = bus.out_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign w_adv[gi] = ~r_valid[gi] | w_adv[gi+1];
    end
  endgenerate

  // in_ready depends only on stage occupancy and out_ready, never on in_valid.
  assign bus.in_ready_o = w_adv[0];
  assign w_accept       = bus.in_valid_i & w_adv[0];

  // Compute the result tuple and the accumulator update for the offered beat.
  always_comb begin
    w_sum      = '0;
    w_res      = '0;
    w_ovf      = 1'b0;
    w_acc_we   = 1'b0;
    w_acc_next = r_acc;
    case (bus.op_i)
      OP_ADD: begin
        w_sum = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        w_ovf = w_sum[WIDTH];
        w_res = w_sum[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_sum = {1'b0, bus.a_i} - {1'b0, bus.b_i};
        w_ovf = (bus.a_i < bus.b_i);
        w_res = w_sum[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf) w_res = '0;
`endif
      end
      OP_ACC: begin
        w_sum = {1'b0, r_acc} + {1'b0, bus.a_i};
        w_ovf = w_sum[WIDTH];
        w_res = w_sum[WIDTH-1:0];
`ifdef PIPE_ADDER_SAT_EN
        if (w_ovf) w_res = '1;
`endif
        // The accumulator keeps exactly what the beat reports.
        w_acc_we   = 1'b1;
        w_acc_next = w_res;
      end
      OP_CLR: begin
        w_res      = r_acc;
        w_ovf      = 1'b0;
        w_acc_we   = 1'b1;
        w_acc_next = '0;
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // Accumulator changes only on accepted ACC/CLR beats, so the next beat sees it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_acc <= '0;
    end else if (w_accept && w_acc_we) begin
      r_acc <= w_acc_next;
    end
  end

  // Shift the {valid,res,ovf} tuples forward wherever a stage advances.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_res[k]   <= '0;
        r_ovf[k]   <= 1'b0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          r_res[0] <= w_res;
          r_ovf[0] <= w_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_res[k]   <= r_res[k-1];
          r_ovf[k]   <= r_ovf[k-1];
        end
      end
    end
  end

  assign bus.out_valid_o = r_valid[STAGES-1];
  assign bus.res_o       = r_res[STAGES-1];
  assign bus.ovf_o       = r_ovf[STAGES-1];
  assign bus.acc_o       = r_acc;

endmodule
